ps2_code_receiver: RTL and testbench
====================================

PS2_CODE_RECEIVER -- requirements
Module: ps2_code_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of scan-code entries buffered; SHALL be a power of two >= 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; the block SHALL use one clock, all logic on posedge clk.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-007 rd_en  input  1  consumer pop request, one entry per cycle.
REQ-008 code  output  8  FIFO head byte (show-ahead), valid while empty=0.
REQ-009 empty  output  1  FIFO holds no entries.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
REQ-012 overflow  output  1  one-cycle pulse when a valid byte is dropped because the FIFO is full.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a two-flop synchronizer; a falling edge SHALL be detected on the synchronized ps2_clk.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP; ps2_data SHALL be sampled only on a detected falling edge.
REQ-015 IDLE: sampled 0 (start bit) -> DATA with bit count 0; sampled 1 -> remain IDLE.
REQ-016 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: capture the parity bit -> STOP.
REQ-018 STOP: frame valid iff the 9 data+parity bits have odd parity and the stop bit is 1; valid -> push byte; invalid -> frame_err pulse, no push; either case -> IDLE.
REQ-019 Push SHALL occur in the cycle of the stop-bit edge detection; empty SHALL deassert on the following clk edge.
REQ-020 In DATA/PARITY/STOP, TIMEOUT_CYCLES consecutive cycles without a falling edge SHALL force IDLE, discard the partial byte and pulse frame_err.
REQ-021 rd_en with empty=0 SHALL advance the head on the next clk edge; rd_en with empty=1 SHALL be ignored.
REQ-022 Push with full=1 and rd_en=0 SHALL drop the byte and pulse overflow; push with full=1 and rd_en=1 in the same cycle SHALL be accepted, with full remaining 1.
REQ-023 Simultaneous push and pop at any non-full occupancy SHALL leave the count unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 code SHALL read 8'h00 while empty=1.

Reset
REQ-025 rst SHALL force IDLE, zero the bit count, timeout counter and pointers, and clear the synchronizers to 1; it SHALL also drive empty=1, full=0, code=8'h00, frame_err=0 and overflow=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame and all buffered entries; the first frame after release SHALL require a fresh start bit.

Configuration
REQ-027 Macro PS2_BREAK_FILTER_EN defined: a valid byte 8'hF0 SHALL set break_pending and not be pushed; the next valid byte SHALL be discarded and clear break_pending; any frame_err SHALL clear break_pending.
REQ-028 Macro PS2_BREAK_FILTER_EN undefined: every valid byte, including 8'hF0, SHALL be pushed, and no break_pending register SHALL exist.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state enum, BREAK_CODE=8'hF0 and EXTEND_CODE=8'hE0.
REQ-030 Buffering SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, empty, full) instantiated once.

Verification
REQ-031 Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> empty falls; code=8'h1C; rd_en one cycle -> empty=1.
REQ-032 Frame 0x1C with parity 1 -> frame_err one pulse; empty stays 1.
REQ-033 Nine valid frames 0x01..0x09, no reads, FIFO_DEPTH=8 -> full=1 after the 8th; overflow pulses on the 9th; reads return 0x01..0x08.
REQ-034 Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next frame 0x32 received correctly.
REQ-035 Frames 0xF0, 0x1C, 0x1B -> with PS2_BREAK_FILTER_EN only 0x1B is queued; without it 0xF0, 0x1C and 0x1B are queued.
REQ-036 rst pulse after 5 data bits with two entries queued -> empty=1, code=8'h00; following frame 0x2A queued alone.

Source files
------------

// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module      : ps2_pkg
// Description : Shared types and scan-code constants for the PS/2 receiver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] BREAK_CODE  = 8'hF0;
   localparam logic [7:0] EXTEND_CODE = 8'hE0;

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/ps2_code_receiver_if.sv
//------------------------------------------------------------------------------
// Module      : ps2_code_receiver_if
// Description : PS/2 line inputs plus scan-code FIFO consumer signals.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ps2_code_receiver_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic [7:0] code;
   logic       empty;
   logic       full;
   logic       frame_err;
   logic       overflow;

   modport master (
      output ps2_clk, ps2_data, rd_en,
      input  code, empty, full, frame_err, overflow
   );

   modport slave (
      input  ps2_clk, ps2_data, rd_en,
      output code, empty, full, frame_err, overflow
   );
endinterface : ps2_code_receiver_if

`default_nettype wire

// File: rtl/ps2_code_receiver_fifo.sv
//------------------------------------------------------------------------------
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO; dout reads zero while empty.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             push,
   input  wire logic             pop,
   input  wire logic [WIDTH-1:0] din,
   output logic      [WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full
);

   localparam int               AW     = $clog2(DEPTH);
   localparam logic [AW:0]      c_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_FULL);
   assign w_pop_ok  = pop & ~empty;
   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign w_push_ok = push & (~full | w_pop_ok);
   assign dout      = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/ps2_code_receiver.sv
//------------------------------------------------------------------------------
// Module      : ps2_code_receiver
// Description : PS/2 frame receiver with scan-code FIFO. Optional break-code
//               filtering is enabled by defining PS2_BREAK_FILTER_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_code_receiver #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input wire logic             clk,
   input wire logic             rst,
   ps2_code_receiver_if.slave   bus
);
   import ps2_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_state_t  r_state;
   logic [1:0]  r_clk_sync;
   logic [1:0]  r_data_sync;
   logic        r_clk_prev;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_parity;
   logic [TW-1:0] r_timeout;
   logic        r_frame_err;
   logic        r_overflow;

   logic        w_fall;
   logic        w_data;
   logic        w_frame_ok;
   logic        w_valid_byte;
   logic        w_stop_err;
   logic        w_timeout_evt;
   logic        w_push;
   logic        w_fifo_full;

   assign w_data        = r_data_sync[1];
   assign w_fall        = r_clk_prev & ~r_clk_sync[1];
   assign w_frame_ok    = (^{r_shift, r_parity}) & w_data;
   assign w_valid_byte  = (r_state == ST_STOP) & w_fall & w_frame_ok;
   assign w_stop_err    = (r_state == ST_STOP) & w_fall & ~w_frame_ok;
   assign w_timeout_evt = (r_state != ST_IDLE) & ~w_fall & (r_timeout == c_TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
         r_data_sync <= {r_data_sync[0], bus.ps2_data};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_parity    <= 1'b0;
         r_timeout   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (r_state == ST_IDLE || w_fall) begin
            r_timeout <= '0;
         end else if (w_timeout_evt) begin
            r_timeout   <= '0;
            r_bit_cnt   <= '0;
            r_state     <= ST_IDLE;
            r_frame_err <= 1'b1;
         end else begin
            r_timeout <= r_timeout + 1'b1;
         end

         if (w_fall) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_data) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {w_data, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_parity <= w_data;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (!w_frame_ok) r_frame_err <= 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef PS2_BREAK_FILTER_EN
   logic r_break_pending;

   // A break prefix swallows itself and the key code that follows it.
   assign w_push = w_valid_byte & ~r_break_pending & (r_shift != BREAK_CODE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_break_pending <= 1'b0;
      end else if (w_stop_err || w_timeout_evt) begin
         r_break_pending <= 1'b0;
      end else if (w_valid_byte) begin
         r_break_pending <= r_break_pending ? 1'b0 : (r_shift == BREAK_CODE);
      end
   end
`else
   assign w_push = w_valid_byte;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_push & w_fifo_full & ~bus.rd_en;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (bus.rd_en),
      .din   (r_shift),
      .dout  (bus.code),
      .empty (bus.empty),
      .full  (w_fifo_full)
   );

   assign bus.full      = w_fifo_full;
   assign bus.frame_err = r_frame_err;
   assign bus.overflow  = r_overflow;

endmodule : ps2_code_receiver

`default_nettype wire

// File: tb/tb_ps2_code_receiver.sv
//------------------------------------------------------------------------------
// Module      : tb_ps2_code_receiver
// Description : Directed self-checking bench for ps2_code_receiver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_code_receiver;

   localparam int DEPTH = 8;
   localparam int TO    = 300;
   localparam int HALF  = 10;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   n_ferr;
   int   n_ovf;
   int   base;

   ps2_code_receiver_if bus ();

   ps2_code_receiver #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.frame_err === 1'b1) n_ferr <= n_ferr + 1;
      if (bus.overflow === 1'b1)  n_ovf  <= n_ovf + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.ps2_data = b;
      repeat (HALF/2) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b) ^ bad_par);
      send_bit(~bad_stop);
      bus.ps2_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] exp);
      check(tag, {31'd0, bus.empty}, 32'd0);
      check(tag, {24'd0, bus.code}, {24'd0, exp});
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; n_ferr = 0; n_ovf = 0;
      bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.rd_en = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_empty", {31'd0, bus.empty}, 32'd1);
      check("rst_full",  {31'd0, bus.full}, 32'd0);
      check("rst_code",  {24'd0, bus.code}, 32'd0);
      check("rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
      check("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // good frame then single pop
      send_frame(8'h1C, 1'b0, 1'b0);
      pop_expect("f1c", 8'h1C);
      check("f1c_empty", {31'd0, bus.empty}, 32'd1);
      check("f1c_code0", {24'd0, bus.code}, 32'd0);

      base = n_ferr;
      send_frame(8'h1C, 1'b1, 1'b0);
      check("par_err", n_ferr - base, 1);
      check("par_empty", {31'd0, bus.empty}, 32'd1);
      base = n_ferr;
      send_frame(8'h55, 1'b0, 1'b1);
      check("stop_err", n_ferr - base, 1);
      check("stop_empty", {31'd0, bus.empty}, 32'd1);

      // fill, overflow, drain
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
      check("fill_full", {31'd0, bus.full}, 32'd1);
      base = n_ovf;
      send_frame(8'h09, 1'b0, 1'b0);
      check("ovf_pulse", n_ovf - base, 1);
      check("ovf_full", {31'd0, bus.full}, 32'd1);
      for (int i = 1; i <= 8; i++) pop_expect($sformatf("drain%0d", i), 8'(i));
      check("drain_empty", {31'd0, bus.empty}, 32'd1);

      // timeout on a partial frame
      base = n_ferr;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (TO + 30) @(negedge clk);
      check("to_err", n_ferr - base, 1);
      check("to_empty", {31'd0, bus.empty}, 32'd1);
      send_frame(8'h32, 1'b0, 1'b0);
      pop_expect("to_next", 8'h32);

      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'h1B, 1'b0, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
      pop_expect("brk_1b", 8'h1B);
`else
      pop_expect("brk_f0", 8'hF0);
      pop_expect("brk_1c", 8'h1C);
      pop_expect("brk_1b", 8'h1B);
`endif
      check("brk_empty", {31'd0, bus.empty}, 32'd1);

      // reset in the middle of a frame with entries queued
      send_frame(8'h11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      #2 rst = 1'b1;
      #1;
      check("mrst_empty", {31'd0, bus.empty}, 32'd1);
      check("mrst_code", {24'd0, bus.code}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_frame(8'h2A, 1'b0, 1'b0);
      pop_expect("mrst_2a", 8'h2A);
      check("mrst_alone", {31'd0, bus.empty}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ps2_code_receiver

`default_nettype wire
